join_multi: RTL
===============

Name: join_multi

Overview:
- Parametrised N-channel valid/ready join; successor to the fixed two-input, 11-bit level-valid join.
- Each input channel feeds a private FIFO so channels may run up to DEPTH tokens ahead of each other.
- When every enabled channel has a token, one token is popped from each and the concatenation is presented on a registered output stage.
- Adds a runtime channel-enable mask and a completed-join counter.
- Sits between independent producers (e.g. ClockedSignal/LevelDetect-driven sources in benches) and a single downstream consumer.

Parameters:
N, 2, number of input channels (>=1)
DW, 11, data width per channel
DEPTH, 2, per-channel FIFO depth (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
i_valid  in  N  per-channel valid
i_ready  out  N  per-channel ready
i_data  in  N*DW  channel k occupies bits [k*DW +: DW]
i_mask  in  N  channel enable; 1 = participates in join
o_valid  out  1  joined word valid
o_ready  in  1  downstream ready
o_data  out  N*DW  joined word, same packing as i_data; masked fields are zero
o_count  out  16  completed output transfers, wraps

Behaviour:
- Reset (rst low, asynchronous): all FIFO pointers cleared; o_valid=0, o_data=0, o_count=0. i_ready is forced to 0 while rst is low.
- Push, channel k:
  - i_ready[k] = rst & i_mask[k] & !full[k]. No same-cycle bypass: a full FIFO deasserts ready even if a pop occurs that cycle.
  - Push occurs when i_valid[k] & i_ready[k].
  - Per-channel order is preserved.
- Join condition J: (i_mask != 0) and every channel with i_mask[k]=1 has a non-empty FIFO.
- Load condition L: J & (!o_valid | o_ready).
  - On L: o_data is loaded with the FIFO heads of enabled channels (zero in masked fields), o_valid is set, and one entry is popped from every enabled FIFO in the same edge.
- Output register behaviour when L is false:
  - If o_valid & o_ready: o_valid clears.
  - Otherwise o_data and o_valid hold.
  - o_data must stay stable while o_valid & !o_ready.
- Latency and throughput:
  - A token pushed at edge t into an empty FIFO (others already present) gives o_valid high after edge t+1, i.e. 2 cycles.
  - Sustained throughput is 1 join/cycle with o_ready held high.
- o_count increments by 1 on each edge where o_valid & o_ready; wraps 0xFFFF->0x0000.
- Masked channels:
  - Neither push nor pop.
  - Contents are retained and become eligible again when re-enabled.
  - Mask is sampled combinationally each cycle.
- i_mask = 0: J is false, no loads. A pending output still drains normally.
- Full/empty:
  - Per-FIFO occupancy 0..DEPTH, using a pointer plus an extra wrap bit.
  - Simultaneous push and pop on a non-full FIFO keeps occupancy unchanged.
- Reset mid-operation discards all buffered tokens and any pending output immediately; no partial state survives.
- X on i_data of a non-pushing channel must not propagate to o_data.

Decomposition:
- Package join_pkg: localparam CNT_W=16; typedef of the count type; a clog2 helper if the toolchain needs one.
- Sub-module join_fifo (DW, DEPTH): synchronous FIFO with push/pop/full/empty/head, async active-low clear on rst. join_multi instantiates N copies in a generate loop.

Test Plan:
- Reset: hold rst=0 for 5 cycles with random i_valid -> i_ready=0, o_valid=0, o_count=0; after release, i_ready=2'b11 with i_mask=2'b11.
- Skewed arrival: push ch0 0x123 at cycle 0 and ch1 0x456 at cycle 3 -> o_valid rises 2 cycles after the ch1 push, o_data={0x456,0x123}; o_count=1 after the handshake.
- Backpressure/full: o_ready=0, push 3 tokens on ch0 only -> i_ready[0]=0 after 2 tokens (DEPTH=2). Then supply ch1 and raise o_ready -> outputs pair in order, no loss or duplication.
- Mask: i_mask=2'b01, push ch0 0x7FF -> o_data={0x000,0x7FF}, i_ready[1]=0. Re-enable ch1 -> previously buffered ch1 tokens pair normally.
- Streaming: both channels valid every cycle, o_ready=1 for 100 cycles -> one join per cycle after the 2-cycle fill, o_count=98 at end of window, data matches the scoreboard.
- Counter wrap and mid-op reset: preload to 0xFFFF via 65535 joins, one more -> o_count=0x0000. Then assert rst mid-stream -> all FIFOs empty, o_valid=0 asynchronously.

Source files
------------

// File: rtl/join_pkg.sv
// Shared types for the N-channel join: transfer-counter width and type.
package join_pkg;

    localparam int CNT_W = 16;

    typedef logic [CNT_W-1:0] count_t;

endpackage

// File: rtl/join_multi_if.sv
// Bundle of the join's input channels and its single joined output.
interface join_multi_if
    import join_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = 11
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both
    // high; a producer must hold valid and data until that edge, while ready may
    // change freely and never waits on valid.
    logic [N-1:0]    i_valid;
    logic [N-1:0]    i_ready;
    logic [N*DW-1:0] i_data;
    logic [N-1:0]    i_mask;
    logic            o_valid;
    logic            o_ready;
    logic [N*DW-1:0] o_data;
    count_t          o_count;

    modport slave (
        input  i_valid, i_data, i_mask, o_ready,
        output i_ready, o_valid, o_data, o_count
    );

    modport master (
        output i_valid, i_data, i_mask, o_ready,
        input  i_ready, o_valid, o_data, o_count
    );

endinterface

// File: rtl/join_fifo.sv
// Per-channel synchronous FIFO; pointers carry one extra wrap bit so that
// occupancy 0..DEPTH is distinguishable without a separate counter.
module join_fifo #(
    parameter int DW    = 11,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] data_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [DW-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: only slots written by a push are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/join_multi.sv
// N-channel valid/ready join: per-channel FIFOs absorb skew, enabled heads are
// concatenated into a registered output word, and completed transfers are counted.
module join_multi
    import join_pkg::*;
#(
    parameter int N     = 2,
    parameter int DW    = 11,
    parameter int DEPTH = 2
) (
    input logic         clk,
    input logic         rst,
    join_multi_if.slave bus
);

    logic [N-1:0]    full, empty, push, pop, ready;
    logic [DW-1:0]   head [N];
    logic [N*DW-1:0] heads;
    logic            join_ok, load;
    logic            o_valid_q, o_valid_d;
    logic [N*DW-1:0] o_data_q, o_data_d;
    count_t          count_q, count_d;

    for (genvar k = 0; k < N; k++) begin : g_ch
        join_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[k]),
            .pop_i   (pop[k]),
            .data_i  (bus.i_data[k*DW +: DW]),
            .full_o  (full[k]),
            .empty_o (empty[k]),
            .head_o  (head[k])
        );
    end

    // Ready looks only at registered fullness, so a pop in the same cycle never
    // re-opens a full channel.
    always_comb begin
        ready   = '0;
        push    = '0;
        heads   = '0;
        join_ok = |bus.i_mask;
        load    = 1'b0;
        pop     = '0;
        for (int k = 0; k < N; k++) begin
            ready[k] = bus.i_mask[k] & ~full[k];
            push[k]  = bus.i_valid[k] & ready[k];
            if (bus.i_mask[k]) begin
                heads[k*DW +: DW] = head[k];
                if (empty[k]) join_ok = 1'b0;
            end
        end
        load = join_ok & (~o_valid_q | bus.o_ready);
        pop  = load ? bus.i_mask : '0;
    end

    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        count_d   = count_q;
        if (load) begin
            o_valid_d = 1'b1;
            o_data_d  = heads;
        end else if (o_valid_q & bus.o_ready) begin
            o_valid_d = 1'b0;
        end
        if (o_valid_q & bus.o_ready) count_d = count_q + count_t'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            count_q   <= '0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            count_q   <= count_d;
        end
    end

    assign bus.i_ready = ready & {N{rst}};
    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = o_data_q;
    assign bus.o_count = count_q;

endmodule
